// File: rtl/l2_response_receiver.sv
// Core-side L2 response receiver: tracks one pending load miss and one pending store per strand,
// turns matching acks into registered L1 fill / strand wake pulses, and flags protocol violations.
module l2_response_receiver #(
    parameter logic [1:0]  CORE_ID      = 2'd0,
    parameter logic [1:0]  UNIT_DCACHE  = 2'd1,
    parameter logic [1:0]  UNIT_STBUF   = 2'd2,
    parameter logic [1:0]  OP_LOAD_ACK  = 2'd0,
    parameter logic [1:0]  OP_STORE_ACK = 2'd1,
    parameter int unsigned LineW        = 512
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             l2rsp_valid_i,
    input  logic             l2rsp_status_i,
    input  logic [1:0]       l2rsp_core_i,
    input  logic [1:0]       l2rsp_unit_i,
    input  logic [1:0]       l2rsp_strand_i,
    input  logic [1:0]       l2rsp_op_i,
    input  logic             l2rsp_update_i,
    input  logic [1:0]       l2rsp_way_i,
    input  logic [LineW-1:0] l2rsp_data_i,
    input  logic             load_issue_i,
    input  logic             store_issue_i,
    input  logic [1:0]       issue_strand_i,
    input  logic [5:0]       issue_set_i,
    output logic             fill_en_o,
    output logic [1:0]       fill_way_o,
    output logic [5:0]       fill_set_o,
    output logic [LineW-1:0] fill_data_o,
    output logic [3:0]       load_wake_o,
    output logic [3:0]       store_wake_o,
    output logic             store_sync_status_o,
    output logic [3:0]       outstanding_o,
    output logic             protocol_error_o
);

    typedef enum logic {StIdle, StPend} pend_e;

    pend_e      ld_state_q [4];
    pend_e      st_state_q [4];
    logic [5:0] ld_set_q   [4];
    logic [5:0] st_set_q   [4];

    logic             fill_en_q;
    logic [1:0]       fill_way_q;
    logic [5:0]       fill_set_q;
    logic [LineW-1:0] fill_data_q;
    logic [3:0]       load_wake_q;
    logic [3:0]       store_wake_q;
    logic             store_sync_q;
    logic [3:0]       outstanding_q;
    logic             protocol_error_q;

    logic       rsp_accept, rsp_load, rsp_store, rsp_error;
    logic [3:0] ld_pend, st_pend;
    logic [3:0] ld_clear, st_clear;
    logic [3:0] ld_busy, st_busy;
    logic       ld_issue_ok, st_issue_ok, issue_error;
    logic [3:0] ld_set_en, st_set_en;
    logic [3:0] ld_pend_next, st_pend_next;
    logic       fill_en_d;
    logic [5:0] fill_set_d;
    logic [3:0] outstanding_d;
    logic       protocol_error_d;

    always_comb begin
        for (int s = 0; s < 4; s++) begin
            ld_pend[s] = (ld_state_q[s] == StPend);
            st_pend[s] = (st_state_q[s] == StPend);
        end
    end

    // Response decode; anything accepted that completes nothing is a protocol error.
    always_comb begin
        rsp_accept = l2rsp_valid_i && (l2rsp_core_i == CORE_ID);
        rsp_load   = rsp_accept && (l2rsp_op_i == OP_LOAD_ACK) &&
                     (l2rsp_unit_i == UNIT_DCACHE) && ld_pend[l2rsp_strand_i];
        rsp_store  = rsp_accept && (l2rsp_op_i == OP_STORE_ACK) &&
                     (l2rsp_unit_i == UNIT_STBUF) && st_pend[l2rsp_strand_i];
        rsp_error  = rsp_accept && !rsp_load && !rsp_store;
        ld_clear   = rsp_load  ? (4'b0001 << l2rsp_strand_i) : 4'b0000;
        st_clear   = rsp_store ? (4'b0001 << l2rsp_strand_i) : 4'b0000;
    end

    // An entry completing this cycle is free to accept a new issue in the same cycle.
    always_comb begin
        ld_busy      = ld_pend & ~ld_clear;
        st_busy      = st_pend & ~st_clear;
        ld_issue_ok  = load_issue_i  && !ld_busy[issue_strand_i];
        st_issue_ok  = store_issue_i && !st_busy[issue_strand_i];
        issue_error  = (load_issue_i  && ld_busy[issue_strand_i]) ||
                       (store_issue_i && st_busy[issue_strand_i]);
        ld_set_en    = ld_issue_ok ? (4'b0001 << issue_strand_i) : 4'b0000;
        st_set_en    = st_issue_ok ? (4'b0001 << issue_strand_i) : 4'b0000;
        ld_pend_next = ld_busy | ld_set_en;
        st_pend_next = st_busy | st_set_en;
    end

    always_comb begin
        fill_en_d        = rsp_load || (rsp_store && l2rsp_update_i);
        fill_set_d       = rsp_load ? ld_set_q[l2rsp_strand_i] : st_set_q[l2rsp_strand_i];
        outstanding_d    = 4'($countones(ld_pend_next)) + 4'($countones(st_pend_next));
        protocol_error_d = protocol_error_q || rsp_error || issue_error;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int s = 0; s < 4; s++) begin
                ld_state_q[s] <= StIdle;
                st_state_q[s] <= StIdle;
                ld_set_q[s]   <= '0;
                st_set_q[s]   <= '0;
            end
            fill_en_q        <= 1'b0;
            fill_way_q       <= '0;
            fill_set_q       <= '0;
            fill_data_q      <= '0;
            load_wake_q      <= '0;
            store_wake_q     <= '0;
            store_sync_q     <= 1'b0;
            outstanding_q    <= '0;
            protocol_error_q <= 1'b0;
        end else begin
            for (int s = 0; s < 4; s++) begin
                unique case (ld_state_q[s])
                    StIdle: begin
                        if (ld_set_en[s]) begin
                            ld_state_q[s] <= StPend;
                            ld_set_q[s]   <= issue_set_i;
                        end
                    end
                    StPend: begin
                        if (ld_set_en[s]) begin
                            ld_set_q[s] <= issue_set_i;
                        end else if (ld_clear[s]) begin
                            ld_state_q[s] <= StIdle;
                        end
                    end
                    default: ld_state_q[s] <= StIdle;
                endcase
                unique case (st_state_q[s])
                    StIdle: begin
                        if (st_set_en[s]) begin
                            st_state_q[s] <= StPend;
                            st_set_q[s]   <= issue_set_i;
                        end
                    end
                    StPend: begin
                        if (st_set_en[s]) begin
                            st_set_q[s] <= issue_set_i;
                        end else if (st_clear[s]) begin
                            st_state_q[s] <= StIdle;
                        end
                    end
                    default: st_state_q[s] <= StIdle;
                endcase
            end
            // Fill address/data fields hold their last value between fills.
            fill_en_q <= fill_en_d;
            if (fill_en_d) begin
                fill_way_q  <= l2rsp_way_i;
                fill_set_q  <= fill_set_d;
                fill_data_q <= l2rsp_data_i;
            end
            load_wake_q      <= ld_clear;
            store_wake_q     <= st_clear;
            store_sync_q     <= rsp_store && l2rsp_status_i;
            outstanding_q    <= outstanding_d;
            protocol_error_q <= protocol_error_d;
        end
    end

    assign fill_en_o           = fill_en_q;
    assign fill_way_o          = fill_way_q;
    assign fill_set_o          = fill_set_q;
    assign fill_data_o         = fill_data_q;
    assign load_wake_o         = load_wake_q;
    assign store_wake_o        = store_wake_q;
    assign store_sync_status_o = store_sync_q;
    assign outstanding_o       = outstanding_q;
    assign protocol_error_o    = protocol_error_q;

endmodule

// File: tb/tb_l2_response_receiver.sv
// Directed bench for l2_response_receiver: behavioural model checked every cycle plus literal checks.
module tb_l2_response_receiver;

    localparam logic [1:0] LdAck = 2'd0;
    localparam logic [1:0] StAck = 2'd1;

    logic         clk = 1'b0;
    logic         reset;
    logic         valid, status, update, load_issue, store_issue;
    logic [1:0]   core, unit, strand, op, way, issue_strand;
    logic [5:0]   issue_set;
    logic [511:0] data;

    logic         fill_en, sync_status, prot_err;
    logic [1:0]   fill_way;
    logic [5:0]   fill_set;
    logic [511:0] fill_data;
    logic [3:0]   load_wake, store_wake, outstanding;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    l2_response_receiver dut (
        .clk_i               (clk),
        .reset_i             (reset),
        .l2rsp_valid_i       (valid),
        .l2rsp_status_i      (status),
        .l2rsp_core_i        (core),
        .l2rsp_unit_i        (unit),
        .l2rsp_strand_i      (strand),
        .l2rsp_op_i          (op),
        .l2rsp_update_i      (update),
        .l2rsp_way_i         (way),
        .l2rsp_data_i        (data),
        .load_issue_i        (load_issue),
        .store_issue_i       (store_issue),
        .issue_strand_i      (issue_strand),
        .issue_set_i         (issue_set),
        .fill_en_o           (fill_en),
        .fill_way_o          (fill_way),
        .fill_set_o          (fill_set),
        .fill_data_o         (fill_data),
        .load_wake_o         (load_wake),
        .store_wake_o        (store_wake),
        .store_sync_status_o (sync_status),
        .outstanding_o       (outstanding),
        .protocol_error_o    (prot_err)
    );

    // Behavioural model: pending tables plus the expected registered outputs.
    bit           m_ldp [4];
    bit           m_stp [4];
    int           m_lds [4];
    int           m_sts [4];
    bit           e_fill_en, e_sync, e_err;
    int           e_way, e_set, e_lw, e_sw, e_out;
    logic [511:0] e_data;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < 4; s++) begin
                m_ldp[s] = 0; m_stp[s] = 0; m_lds[s] = 0; m_sts[s] = 0;
            end
            e_fill_en = 0; e_sync = 0; e_err = 0;
            e_way = 0; e_set = 0; e_lw = 0; e_sw = 0; e_out = 0; e_data = '0;
        end else begin
            e_fill_en = 0; e_lw = 0; e_sw = 0; e_sync = 0;
            if (valid && core == 2'd0) begin
                if (op == LdAck && unit == 2'd1 && m_ldp[strand]) begin
                    e_fill_en = 1; e_way = way; e_set = m_lds[strand]; e_data = data;
                    e_lw = 1 << strand;
                    m_ldp[strand] = 0;
                end else if (op == StAck && unit == 2'd2 && m_stp[strand]) begin
                    e_sw = 1 << strand; e_sync = status;
                    if (update) begin
                        e_fill_en = 1; e_way = way; e_set = m_sts[strand]; e_data = data;
                    end
                    m_stp[strand] = 0;
                end else begin
                    e_err = 1;
                end
            end
            if (load_issue) begin
                if (m_ldp[issue_strand]) e_err = 1;
                else begin m_ldp[issue_strand] = 1; m_lds[issue_strand] = issue_set; end
            end
            if (store_issue) begin
                if (m_stp[issue_strand]) e_err = 1;
                else begin m_stp[issue_strand] = 1; m_sts[issue_strand] = issue_set; end
            end
            e_out = 0;
            for (int s = 0; s < 4; s++) e_out += m_ldp[s] + m_stp[s];
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            chk("m.fill_en", int'(fill_en), int'(e_fill_en));
            chk("m.fill_way", int'(fill_way), e_way);
            chk("m.fill_set", int'(fill_set), e_set);
            chk("m.load_wake", int'(load_wake), e_lw);
            chk("m.store_wake", int'(store_wake), e_sw);
            chk("m.sync_status", int'(sync_status), int'(e_sync));
            chk("m.outstanding", int'(outstanding), e_out);
            chk("m.protocol_error", int'(prot_err), int'(e_err));
            n_cmp++;
            if (fill_data !== e_data) begin
                n_bad++;
                $display("FAIL m.fill_data: got %0h, expected %0h", fill_data[31:0], e_data[31:0]);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        valid = 0; status = 0; update = 0; core = 0; unit = 0; strand = 0; op = 0; way = 0;
        load_issue = 0; store_issue = 0; issue_strand = 0; issue_set = 0;
    endtask

    task automatic issue(input bit is_load, input int s, input int set);
        idle();
        load_issue = is_load; store_issue = !is_load;
        issue_strand = 2'(s); issue_set = 6'(set);
        tick();
        idle();
    endtask

    task automatic rsp(input int c, input int o, input int u, input int s, input int w,
                       input bit st, input bit up, input logic [511:0] d, input bit keep);
        if (!keep) idle();
        valid = 1; core = 2'(c); op = 2'(o); unit = 2'(u); strand = 2'(s); way = 2'(w);
        status = st; update = up; data = d;
        tick();
        idle();
    endtask

    initial begin
        idle();
        data  = '0;
        reset = 1;
        tick(); tick();
        reset = 0;
        tick();
        chk("reset.outstanding", int'(outstanding), 0);
        chk("reset.fill_en", int'(fill_en), 0);
        chk("reset.protocol_error", int'(prot_err), 0);

        // Load fill to strand 2.
        issue(1, 2, 'h15);
        chk("ld.outstanding_1", int'(outstanding), 1);
        rsp(0, LdAck, 1, 2, 3, 0, 0, {16{32'hA5A5_0001}}, 0);
        chk("ld.fill_en", int'(fill_en), 1);
        chk("ld.fill_way", int'(fill_way), 3);
        chk("ld.fill_set", int'(fill_set), 'h15);
        chk("ld.load_wake", int'(load_wake), 'b0100);
        chk("ld.outstanding_0", int'(outstanding), 0);
        chk("ld.data_word", int'(fill_data[63:32]), 'hA5A5_0001);
        tick();
        chk("ld.fill_pulse", int'(fill_en), 0);

        // Store with update, then store without update and status 0.
        issue(0, 1, 'h3F);
        rsp(0, StAck, 2, 1, 0, 1, 1, {16{32'h0BAD_F00D}}, 0);
        chk("st.store_wake", int'(store_wake), 'b0010);
        chk("st.sync", int'(sync_status), 1);
        chk("st.fill_en", int'(fill_en), 1);
        chk("st.fill_set", int'(fill_set), 'h3F);
        issue(0, 2, 'h0A);
        rsp(0, StAck, 2, 2, 1, 0, 0, {16{32'h1234_5678}}, 0);
        chk("st2.store_wake", int'(store_wake), 'b0100);
        chk("st2.fill_en", int'(fill_en), 0);
        chk("st2.sync", int'(sync_status), 0);

        // Foreign core is ignored.
        issue(1, 0, 'h01);
        rsp(1, LdAck, 1, 0, 2, 0, 0, {16{32'hDEAD_0000}}, 0);
        chk("core.fill_en", int'(fill_en), 0);
        chk("core.load_wake", int'(load_wake), 0);
        chk("core.protocol_error", int'(prot_err), 0);
        chk("core.outstanding", int'(outstanding), 1);
        rsp(0, LdAck, 1, 0, 2, 0, 0, {16{32'h0000_0C0C}}, 0);
        chk("core.own_fill", int'(fill_en), 1);

        // Unmatched ack is sticky error; double issue is dropped.
        rsp(0, LdAck, 1, 0, 0, 0, 0, '0, 0);
        chk("err.set", int'(prot_err), 1);
        chk("err.no_fill", int'(fill_en), 0);
        tick(); tick();
        chk("err.sticky", int'(prot_err), 1);
        issue(1, 3, 'h11);
        issue(1, 3, 'h22);
        chk("dbl.outstanding", int'(outstanding), 1);
        rsp(0, LdAck, 1, 3, 1, 0, 0, {16{32'h3333_3333}}, 0);
        chk("dbl.kept_first_set", int'(fill_set), 'h11);
        chk("dbl.outstanding_0", int'(outstanding), 0);

        // Same-cycle completion and reissue on strand 1.
        issue(1, 1, 'h2A);
        idle();
        load_issue = 1; issue_strand = 1; issue_set = 'h07;
        rsp(0, LdAck, 1, 1, 2, 0, 0, {16{32'h7777_0000}}, 1);
        chk("same.load_wake", int'(load_wake), 'b0010);
        chk("same.fill_set_old", int'(fill_set), 'h2A);
        chk("same.outstanding", int'(outstanding), 1);
        rsp(0, LdAck, 1, 1, 0, 0, 0, {16{32'h7777_0001}}, 0);
        chk("same.fill_set_new", int'(fill_set), 'h07);
        chk("same.outstanding_0", int'(outstanding), 0);

        // Fill every entry, then reset mid-stream.
        for (int s = 0; s < 4; s++) issue(1, s, s);
        for (int s = 0; s < 4; s++) issue(0, s, 'h20 + s);
        chk("full.outstanding", int'(outstanding), 8);
        reset = 1;
        #2;
        chk("rst.outstanding", int'(outstanding), 0);
        chk("rst.protocol_error", int'(prot_err), 0);
        tick();
        reset = 0;
        tick();
        rsp(0, LdAck, 1, 0, 0, 0, 0, '0, 0);
        chk("rst.late_ack_error", int'(prot_err), 1);
        chk("rst.late_ack_fill", int'(fill_en), 0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
